// File: rtl/ud_count_monitor_if.sv
// Bundle of the signals exchanged between the 3-bit up/down counter side
// (observed values plus monitor controls) and the ud_count_monitor.
// master: the environment driving the observed counter signals and clr.
// slave : the monitor, which consumes them and drives the status outputs.
interface ud_count_monitor_if #(
  parameter int unsigned WRAP_W = 8
);
  logic [2:0]        q;
  logic              ud;
  logic              cnt_rst;
  logic              clr;
  logic              locked;
  logic              step_err;
  logic              err_sticky;
  logic              wrap_up;
  logic              wrap_dn;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output q, ud, cnt_rst, clr,
    input  locked, step_err, err_sticky, wrap_up, wrap_dn, wrap_cnt
  );

  modport slave (
    input  q, ud, cnt_rst, clr,
    output locked, step_err, err_sticky, wrap_up, wrap_dn, wrap_cnt
  );
endinterface

// File: rtl/ud_count_monitor.sv
// Downstream checker for a 3-bit up/down synchronous counter sharing clk.
// Each edge it registers (q, ud, cnt_rst); at the following edge it predicts
// the counter value from those registered inputs and compares it with q.
// A run of LOCK_CNT legal steps enters LOCK; any illegal step reports a
// one-cycle step_err and drops back to acquisition. Legal 7->0 (up) and
// 0->7 (down) steps are reported as wraps and counted in a saturating
// counter. clr zeroes err_sticky and wrap_cnt without touching the FSM.
//
// Optional feature, macro MON_HOLD_EN: when defined, q repeating its previous
// value (with no counter clear pending) is accepted as a hold, for counters
// gated by an enable; the hold neither errors nor advances lock progress.
//
// rst_n is expected to be released synchronously to clk by the reset
// distribution upstream; assertion takes effect immediately.
module ud_count_monitor #(
  parameter int unsigned LOCK_CNT = 4,  // legal steps needed to lock (1..15)
  parameter int unsigned WRAP_W   = 8   // width of the wrap event counter
) (
  input logic              clk,
  input logic              rst_n,
  ud_count_monitor_if.slave mon
);

  localparam int unsigned GOOD_W = 4;
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [GOOD_W-1:0]   good_cnt;
  logic [GOOD_W-1:0]   good_next;

  logic [2:0]          q_d;
  logic                ud_d;
  logic                rst_d;

  logic [2:0]          exp_q;
  logic                legal;
  logic                hold;
  logic                err_det;
  logic                wrap_up_det;
  logic                wrap_dn_det;

  logic                locked_r;
  logic                step_err_r;
  logic                err_sticky_r;
  logic                wrap_up_r;
  logic                wrap_dn_r;
  logic [WRAP_W-1:0]   wrap_cnt_r;

  // Sample the counter's inputs and output so the next edge can predict q.
  // NOTE: every flop uses non-blocking assignment so all registers update
  // from pre-edge values, regardless of block ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_d   <= 3'd0;
      ud_d  <= 1'b0;
      rst_d <= 1'b0;
    end else begin
      q_d   <= mon.q;
      ud_d  <= mon.ud;
      rst_d <= mon.cnt_rst;
    end
  end

  // Predicted counter value: clear wins, otherwise +/-1 with 3-bit wrap.
  assign exp_q = rst_d ? 3'd0 : (ud_d ? q_d + 3'd1 : q_d - 3'd1);
  assign legal = (mon.q == exp_q);

`ifdef MON_HOLD_EN
  // An enable-gated counter may legitimately keep its value.
  assign hold = !rst_d && (mon.q == q_d);
`else
  assign hold = 1'b0;
`endif

  // Next-state, lock progress and event detection for the current sample.
  // NOTE: all outputs of this block get a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    good_next   = good_cnt;
    err_det     = 1'b0;
    wrap_up_det = 1'b0;
    wrap_dn_det = 1'b0;

    unique case (state)
      INIT: begin
        state_next = ACQ;
        good_next  = '0;
      end

      ACQ, LOCK: begin
        if (legal) begin
          wrap_up_det = !rst_d &&  ud_d && (q_d == 3'd7) && (mon.q == 3'd0);
          wrap_dn_det = !rst_d && !ud_d && (q_d == 3'd0) && (mon.q == 3'd7);
          if (state == ACQ) begin
            if (good_cnt == GOOD_LAST) begin
              state_next = LOCK;
              good_next  = '0;
            end else begin
              good_next = good_cnt + 1'b1;
            end
          end
        end else if (!hold) begin
          err_det    = 1'b1;
          state_next = ACQ;
          good_next  = '0;
        end
      end

      default: begin
        state_next = INIT;
        good_next  = '0;
      end
    endcase
  end

  // FSM state and lock progress registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      good_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
    end
  end

  // Registered status: lock level and one-cycle event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_r   <= 1'b0;
      step_err_r <= 1'b0;
      wrap_up_r  <= 1'b0;
      wrap_dn_r  <= 1'b0;
    end else begin
      locked_r   <= (state_next == LOCK);
      step_err_r <= err_det;
      wrap_up_r  <= wrap_up_det;
      wrap_dn_r  <= wrap_dn_det;
    end
  end

  // Sticky error (new error beats clr) and saturating wrap count (clr wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_r <= 1'b0;
      wrap_cnt_r   <= '0;
    end else begin
      if (err_det) begin
        err_sticky_r <= 1'b1;
      end else if (mon.clr) begin
        err_sticky_r <= 1'b0;
      end

      if (mon.clr) begin
        wrap_cnt_r <= '0;
      end else if ((wrap_up_det || wrap_dn_det) && (wrap_cnt_r != '1)) begin
        wrap_cnt_r <= wrap_cnt_r + 1'b1;
      end
    end
  end

  assign mon.locked     = locked_r;
  assign mon.step_err   = step_err_r;
  assign mon.err_sticky = err_sticky_r;
  assign mon.wrap_up    = wrap_up_r;
  assign mon.wrap_dn    = wrap_dn_r;
  assign mon.wrap_cnt   = wrap_cnt_r;

endmodule

// File: tb/tb_ud_count_monitor.sv
// Self-checking bench for ud_count_monitor. A behavioural counter drives the
// monitor; a reference model of the checking rules predicts every output.
// Honours MON_HOLD_EN the same way as the design.
module tb_ud_count_monitor;

  localparam int LOCK_CNT = 4;
  localparam int WRAP_W   = 8;
  localparam int WRAP_MAX = (1 << WRAP_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ud_count_monitor_if #(.WRAP_W(WRAP_W)) bus ();

  ud_count_monitor #(.LOCK_CNT(LOCK_CNT), .WRAP_W(WRAP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural counter value to present next.
  logic [2:0] cq = 3'd0;

  // Reference model: last sample, lock progress, expected outputs.
  bit   m_init;
  bit   m_locked;
  int   m_streak;
  bit   m_err, m_wu, m_wd, m_sticky;
  int   m_wcnt;
  int   p_q;
  bit   p_ud, p_rst;

  task automatic model_reset();
    m_init = 1; m_locked = 0; m_streak = 0;
    m_err = 0; m_wu = 0; m_wd = 0; m_sticky = 0; m_wcnt = 0;
    p_q = 0; p_ud = 0; p_rst = 0;
  endtask

  // One clock: present a sample, advance the model, compare all outputs.
  task automatic cycle(input logic [2:0] qv, input bit udv, input bit rstv,
                       input bit clrv, input string tag);
    int expv;
    bit hold;
    bus.q = qv; bus.ud = udv; bus.cnt_rst = rstv; bus.clr = clrv;
    @(posedge clk);
    m_err = 0; m_wu = 0; m_wd = 0;
    if (m_init) begin
      m_init = 0;
    end else begin
      expv = p_rst ? 0 : (p_ud ? (p_q + 1) % 8 : (p_q + 7) % 8);
      hold = 0;
`ifdef MON_HOLD_EN
      hold = !p_rst && (int'(qv) == p_q);
`endif
      if (int'(qv) == expv) begin
        m_wu = !p_rst &&  p_ud && p_q == 7;
        m_wd = !p_rst && !p_ud && p_q == 0;
        if (!m_locked) begin
          m_streak++;
          if (m_streak == LOCK_CNT) begin
            m_locked = 1;
            m_streak = 0;
          end
        end
      end else if (!hold) begin
        m_err = 1; m_locked = 0; m_streak = 0;
      end
    end
    if (clrv) m_wcnt = 0;
    else if ((m_wu || m_wd) && m_wcnt < WRAP_MAX) m_wcnt++;
    if (m_err) m_sticky = 1;
    else if (clrv) m_sticky = 0;
    p_q = int'(qv); p_ud = udv; p_rst = rstv;
    #1;
    n_checks += 6;
    if (bus.locked !== m_locked) begin
      n_err++; $display("FAIL %s locked: got %0b want %0b", tag, bus.locked, m_locked);
    end
    if (bus.step_err !== m_err) begin
      n_err++; $display("FAIL %s step_err: got %0b want %0b", tag, bus.step_err, m_err);
    end
    if (bus.err_sticky !== m_sticky) begin
      n_err++; $display("FAIL %s err_sticky: got %0b want %0b", tag, bus.err_sticky, m_sticky);
    end
    if (bus.wrap_up !== m_wu) begin
      n_err++; $display("FAIL %s wrap_up: got %0b want %0b", tag, bus.wrap_up, m_wu);
    end
    if (bus.wrap_dn !== m_wd) begin
      n_err++; $display("FAIL %s wrap_dn: got %0b want %0b", tag, bus.wrap_dn, m_wd);
    end
    if (bus.wrap_cnt !== WRAP_W'(m_wcnt)) begin
      n_err++; $display("FAIL %s wrap_cnt: got %0d want %0d", tag, bus.wrap_cnt, m_wcnt);
    end
  endtask

  // Present the counter's value, then let it advance like a real counter.
  task automatic run(input bit udv, input bit rstv, input bit clrv, input string tag);
    cycle(cq, udv, rstv, clrv, tag);
    cq = rstv ? 3'd0 : (udv ? cq + 3'd1 : cq - 3'd1);
  endtask

  task automatic test_reset();
    bus.q = 3'd0; bus.ud = 1'b0; bus.cnt_rst = 1'b0; bus.clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.locked, bus.step_err, bus.err_sticky, bus.wrap_up, bus.wrap_dn} !== 5'b0) begin
      n_err++; $display("FAIL reset flags: got %b want 00000",
        {bus.locked, bus.step_err, bus.err_sticky, bus.wrap_up, bus.wrap_dn});
    end
    n_checks++;
    if (bus.wrap_cnt !== '0) begin
      n_err++; $display("FAIL reset wrap_cnt: got %0d want 0", bus.wrap_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cq = 3'd0;
  endtask

  task automatic test_count_up();
    for (int i = 0; i <= 10; i++) begin
      run(1'b1, 1'b0, 1'b0, "count_up");
      if (i == 3) begin
        n_checks++;
        if (bus.locked !== 1'b0) begin
          n_err++; $display("FAIL count_up early_lock: got %0b want 0", bus.locked);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (bus.locked !== 1'b1) begin
          n_err++; $display("FAIL count_up lock_4th: got %0b want 1", bus.locked);
        end
      end
      if (i == 8) begin
        n_checks++;
        if (bus.wrap_up !== 1'b1) begin
          n_err++; $display("FAIL count_up wrap_7to0: got %0b want 1", bus.wrap_up);
        end
      end
    end
    n_checks++;
    if (bus.wrap_cnt !== 8'd1 || bus.err_sticky !== 1'b0) begin
      n_err++; $display("FAIL count_up totals: got wrap_cnt=%0d sticky=%0b want 1/0",
        bus.wrap_cnt, bus.err_sticky);
    end
  endtask

  task automatic test_wrap_down();
    int w0;
    for (int i = 0; i < 8 && cq != 3'd0; i++) run(1'b1, 1'b0, 1'b0, "wrap_dn_prep");
    run(1'b0, 1'b0, 1'b0, "wrap_dn_at0");
    w0 = m_wcnt;
    run(1'b0, 1'b0, 1'b0, "wrap_dn_0to7");
    n_checks++;
    if (bus.wrap_dn !== 1'b1 || bus.locked !== 1'b1 || bus.wrap_cnt !== 8'(w0 + 1)) begin
      n_err++; $display("FAIL wrap_dn event: got dn=%0b locked=%0b cnt=%0d want 1/1/%0d",
        bus.wrap_dn, bus.locked, bus.wrap_cnt, w0 + 1);
    end
  endtask

  task automatic test_step_error();
    for (int i = 0; i < 8 && cq != 3'd3; i++) run(1'b1, 1'b0, 1'b0, "err_prep");
    run(1'b1, 1'b0, 1'b0, "err_at3");
    cq = 3'd6;
    run(1'b1, 1'b0, 1'b0, "err_force6");
    n_checks++;
    if (bus.step_err !== 1'b1 || bus.err_sticky !== 1'b1 || bus.locked !== 1'b0) begin
      n_err++; $display("FAIL step_err event: got err=%0b sticky=%0b locked=%0b want 1/1/0",
        bus.step_err, bus.err_sticky, bus.locked);
    end
    for (int i = 1; i <= 4; i++) begin
      run(1'b1, 1'b0, 1'b0, "err_relock");
      if (i == 1) begin
        n_checks++;
        if (bus.step_err !== 1'b0) begin
          n_err++; $display("FAIL step_err width: got %0b want 0", bus.step_err);
        end
      end
      n_checks++;
      if (bus.locked !== (i == 4)) begin
        n_err++; $display("FAIL relock step%0d: got %0b want %0b", i, bus.locked, i == 4);
      end
    end
  endtask

  task automatic test_counter_clear();
    for (int i = 0; i < 8 && cq != 3'd5; i++) run(1'b1, 1'b0, 1'b0, "cclr_prep");
    run(1'b1, 1'b1, 1'b0, "cclr_rst");
    run(1'b1, 1'b0, 1'b0, "cclr_zero");
    n_checks++;
    if (bus.step_err !== 1'b0 || bus.wrap_up !== 1'b0 || bus.wrap_dn !== 1'b0 ||
        bus.locked !== 1'b1) begin
      n_err++; $display("FAIL cnt_rst legal: got err=%0b up=%0b dn=%0b locked=%0b want 0/0/0/1",
        bus.step_err, bus.wrap_up, bus.wrap_dn, bus.locked);
    end
  endtask

  task automatic test_clr();
    cq = cq + 3'd3;
    run(1'b1, 1'b0, 1'b1, "clr_with_err");
    n_checks++;
    if (bus.err_sticky !== 1'b1) begin
      n_err++; $display("FAIL clr_vs_err sticky: got %0b want 1", bus.err_sticky);
    end
    run(1'b1, 1'b0, 1'b1, "clr_plain");
    n_checks++;
    if (bus.err_sticky !== 1'b0) begin
      n_err++; $display("FAIL clr sticky: got %0b want 0", bus.err_sticky);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8 && cq != 3'd7; i++) run(1'b1, 1'b0, 1'b0, "sat_prep");
    run(1'b1, 1'b0, 1'b1, "sat_clear");
    for (int w = 0; w < WRAP_MAX; w++)
      for (int s = 0; s < 8; s++) run(1'b1, 1'b0, 1'b0, "sat_fill");
    n_checks++;
    if (bus.wrap_cnt !== 8'd255) begin
      n_err++; $display("FAIL sat 255_wraps: got %0d want 255", bus.wrap_cnt);
    end
    run(1'b1, 1'b0, 1'b0, "sat_extra");
    n_checks++;
    if (bus.wrap_up !== 1'b1 || bus.wrap_cnt !== 8'd255) begin
      n_err++; $display("FAIL sat hold: got up=%0b cnt=%0d want 1/255", bus.wrap_up, bus.wrap_cnt);
    end
    for (int s = 0; s < 7; s++) run(1'b1, 1'b0, 1'b0, "sat_to7");
    run(1'b1, 1'b0, 1'b1, "sat_clr_wrap");
    n_checks++;
    if (bus.wrap_up !== 1'b1 || bus.wrap_cnt !== 8'd0) begin
      n_err++; $display("FAIL clr_vs_wrap: got up=%0b cnt=%0d want 1/0", bus.wrap_up, bus.wrap_cnt);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 8 && cq != 3'd2; i++) run(1'b1, 1'b0, 1'b0, "hold_prep");
    run(1'b1, 1'b0, 1'b0, "hold_at2");
    for (int i = 0; i < 3; i++) begin
      cycle(3'd2, 1'b1, 1'b0, 1'b0, "hold");
      if (i == 0) begin
        n_checks++;
`ifdef MON_HOLD_EN
        if (bus.step_err !== 1'b0 || bus.locked !== 1'b1) begin
          n_err++; $display("FAIL hold accepted: got err=%0b locked=%0b want 0/1",
            bus.step_err, bus.locked);
        end
`else
        if (bus.step_err !== 1'b1 || bus.locked !== 1'b0) begin
          n_err++; $display("FAIL hold rejected: got err=%0b locked=%0b want 1/0",
            bus.step_err, bus.locked);
        end
`endif
      end
    end
    cq = 3'd3;
    for (int i = 0; i < 6; i++) run(1'b1, 1'b0, 1'b0, "hold_resume");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(11) == 0) cq = 3'($urandom);
      run(1'($urandom), $urandom_range(9) == 0, $urandom_range(15) == 0, "random");
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) run(1'b1, 1'b0, 1'b0, "rst_mid_prep");
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.locked, bus.step_err, bus.err_sticky, bus.wrap_up, bus.wrap_dn} !== 5'b0 ||
        bus.wrap_cnt !== '0) begin
      n_err++; $display("FAIL async reset: got flags=%b cnt=%0d want 00000/0",
        {bus.locked, bus.step_err, bus.err_sticky, bus.wrap_up, bus.wrap_dn}, bus.wrap_cnt);
    end
    model_reset();
    cq = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run(1'b0, 1'b0, 1'b0, "rst_mid_after");
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_down();
    test_step_error();
    test_counter_clear();
    test_clr();
    test_saturation();
    test_hold();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
